// File: rtl/blit_sdram_arb_pkg.sv
// Shared types for the blitter SDRAM port arbiter: FSM state encoding and the
// write-streak counter helpers.
package blit_sdram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WR      = 2'd1,
    ARB_RD      = 2'd2,
    ARB_RD_WAIT = 2'd3
  } blit_arb_state_t;

  localparam int         STREAK_W   = 8;
  localparam logic [7:0] STREAK_SAT = 8'hFF;

  // Increment that sticks at the top of the counter range instead of wrapping.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cnt);
    return (cnt == STREAK_SAT) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/blit_sdram_arb_if.sv
// One SDRAM-style request port. Handshake: master raises req with write/addr/
// wdata/byte_enable stable and holds them until the slave pulses ack for one
// cycle; read beats return later on rdata/rdvalid, finished by complete.
interface blit_sdram_arb_if #(
  parameter int ADDR_W = 26
);
  logic              req;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        byte_enable;
  logic              ack;
  logic [31:0]       rdata;
  logic              rdvalid;
  logic              complete;

  modport master (
    output req, write, addr, wdata, byte_enable,
    input  ack, rdata, rdvalid, complete
  );

  modport slave (
    input  req, write, addr, wdata, byte_enable,
    output ack, rdata, rdvalid, complete
  );
endinterface

// File: rtl/blit_sdram_arb.sv
// Arbitrates the blitter write port and source-read port onto one SDRAM master
// port, keeping reads ordered after accepted writes and bounding write streaks.
module blit_sdram_arb
  import blit_sdram_arb_pkg::*;
#(
  parameter int MAX_WR_STREAK = 8,
  parameter int ADDR_W        = 26
) (
  input  logic                  clock,
  input  logic                  reset,
  blit_sdram_arb_if.slave       blitw,
  blit_sdram_arb_if.slave       blitr,
  blit_sdram_arb_if.master      sdram,
  output logic                  arb_busy,
  output blit_arb_state_t       dbg_state,
  output logic [STREAK_W-1:0]   dbg_streak
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_WR_STREAK);

  blit_arb_state_t       state_q, state_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic [ADDR_W-1:0]     addr_mux;
  logic                  unused_inputs;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      ARB_IDLE: begin
        // Writes go first unless they have already held off a waiting read long enough.
        if (blitw.req && blitr.req) begin
          state_d = (streak_q >= MAX_STREAK) ? ARB_RD : ARB_WR;
        end else if (blitw.req) begin
          state_d = ARB_WR;
        end else if (blitr.req) begin
          state_d = ARB_RD;
        end
      end
      ARB_WR: begin
        if (sdram.ack) begin
          state_d  = ARB_IDLE;
          streak_d = blitr.req ? streak_inc(streak_q) : '0;
        end
      end
      ARB_RD: begin
        if (sdram.ack) begin
          state_d  = ARB_RD_WAIT;
          streak_d = '0;
        end
      end
      ARB_RD_WAIT: begin
        if (sdram.complete) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    addr_mux = '0;
    if (state_q == ARB_WR)      addr_mux = blitw.addr;
    else if (state_q == ARB_RD) addr_mux = blitr.addr;
  end

  assign sdram.req         = (state_q == ARB_WR) || (state_q == ARB_RD);
  assign sdram.write       = (state_q == ARB_WR);
  assign sdram.addr        = addr_mux;
  assign sdram.wdata       = (state_q == ARB_WR) ? blitw.wdata : 32'h0;
  assign sdram.byte_enable = (state_q == ARB_WR) ? blitw.byte_enable :
                             (state_q == ARB_RD) ? 4'hF : 4'h0;

  // A downstream ack only counts while a request is actually being presented.
  assign blitw.ack = (state_q == ARB_WR) && sdram.ack;
  assign blitr.ack = (state_q == ARB_RD) && sdram.ack;

  assign blitr.rdata    = sdram.rdata;
  assign blitr.rdvalid  = sdram.rdvalid;
  assign blitr.complete = sdram.complete;

  assign blitw.rdata    = 32'h0;
  assign blitw.rdvalid  = 1'b0;
  assign blitw.complete = 1'b0;

  assign arb_busy   = (state_q != ARB_IDLE);
  assign dbg_state  = state_q;
  assign dbg_streak = streak_q;

  assign unused_inputs = ^{blitw.write, blitr.write, blitr.wdata, blitr.byte_enable};

endmodule

// File: tb/tb_blit_sdram_arb.sv
// Bench for blit_sdram_arb: requester queues feed both upstream ports, a
// hand-driven SDRAM responder answers, and grants are checked in order.
module tb_blit_sdram_arb;
  import blit_sdram_arb_pkg::*;

  localparam int ADDR_W        = 26;
  localparam int MAX_WR_STREAK = 8;
  localparam int W             = 1 + ADDR_W + 32 + 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  blit_sdram_arb_if #(.ADDR_W(ADDR_W)) blitw ();
  blit_sdram_arb_if #(.ADDR_W(ADDR_W)) blitr ();
  blit_sdram_arb_if #(.ADDR_W(ADDR_W)) sdram ();

  logic            arb_busy;
  blit_arb_state_t dbg_state;
  logic [7:0]      dbg_streak;

  blit_sdram_arb #(.MAX_WR_STREAK(MAX_WR_STREAK), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .blitw      (blitw),
    .blitr      (blitr),
    .sdram      (sdram),
    .arb_busy   (arb_busy),
    .dbg_state  (dbg_state),
    .dbg_streak (dbg_streak)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } req_t;

  typedef struct {
    logic              use_w;
    logic              use_r;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_data;
    logic [3:0]        w_be;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    int                ack_dly;
    int                beat_dly;
  } vec_t;

  req_t         w_pend_q[$];
  req_t         r_pend_q[$];
  logic [W-1:0] exp_q[$];
  vec_t         vecs[6];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requesters: present the queue head, advance it after an observed ack.
  initial begin : requester_drv
    logic ack_w, ack_r;
    blitw.req = 1'b0; blitw.write = 1'b1; blitw.addr = '0; blitw.wdata = '0; blitw.byte_enable = '0;
    blitr.req = 1'b0; blitr.write = 1'b0; blitr.addr = '0; blitr.wdata = '0; blitr.byte_enable = '0;
    forever begin
      @(negedge clock);
      #4;
      ack_w = blitw.ack;
      ack_r = blitr.ack;
      @(posedge clock);
      #1;
      if (ack_w && w_pend_q.size() > 0) void'(w_pend_q.pop_front());
      if (ack_r && r_pend_q.size() > 0) void'(r_pend_q.pop_front());
      if (w_pend_q.size() > 0) begin
        blitw.req = 1'b1; blitw.addr = w_pend_q[0].addr;
        blitw.wdata = w_pend_q[0].data; blitw.byte_enable = w_pend_q[0].be;
      end else begin
        blitw.req = 1'b0;
      end
      if (r_pend_q.size() > 0) begin
        blitr.req = 1'b1; blitr.addr = r_pend_q[0].addr;
      end else begin
        blitr.req = 1'b0;
      end
    end
  end

  task automatic push_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    req_t r;
    r.addr = a; r.data = d; r.be = be;
    w_pend_q.push_back(r);
  endtask

  task automatic push_read(input logic [ADDR_W-1:0] a);
    req_t r;
    r.addr = a; r.data = '0; r.be = '0;
    r_pend_q.push_back(r);
  endtask

  // Wait for a downstream request, compare it with the scoreboard head, ack it.
  task automatic grant_and_ack(input int ack_dly, output logic is_wr, output logic ok);
    logic [W-1:0] exp;
    int n;
    n = 0;
    is_wr = 1'b0;
    ok = 1'b0;
    while (sdram.req !== 1'b1 && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (sdram.req !== 1'b1) begin
      check("req_timeout", 64'(sdram.req), 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_req", 64'd1, 64'd0);
      return;
    end
    exp = exp_q.pop_front();
    is_wr = exp[W-1];
    ok = 1'b1;
    check("grant_kind", 64'(sdram.write), 64'(is_wr));
    check("grant_addr", 64'(sdram.addr), 64'(exp[W-2 -: ADDR_W]));
    check("grant_be", 64'(sdram.byte_enable), 64'(exp[3:0]));
    if (is_wr) check("grant_wdata", 64'(sdram.wdata), 64'(exp[35:4]));
    check("busy_granted", 64'(arb_busy), 64'd1);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clock); #1;
      check("req_held", 64'(sdram.req), 64'd1);
      check("no_early_ack", 64'({blitw.ack, blitr.ack}), 64'd0);
    end
    sdram.ack = 1'b1;
    #1;
    check("up_ack", 64'({blitw.ack, blitr.ack}), is_wr ? 64'd2 : 64'd1);
    @(negedge clock);
    sdram.ack = 1'b0;
    #1;
    check("ack_pulse", 64'({blitw.ack, blitr.ack}), 64'd0);
    check("turnaround", 64'(sdram.req), 64'd0);
    check("post_ack_state", 64'(dbg_state), is_wr ? 64'(ARB_IDLE) : 64'(ARB_RD_WAIT));
  endtask

  task automatic read_finish(input int beat_dly, input logic [31:0] data);
    for (int i = 0; i < beat_dly; i++) begin
      @(negedge clock); #1;
      check("rdwait_no_req", 64'(sdram.req), 64'd0);
      check("rdwait_state", 64'(dbg_state), 64'(ARB_RD_WAIT));
    end
    @(negedge clock);
    sdram.rdata = data; sdram.rdvalid = 1'b1; sdram.complete = 1'b1;
    #1;
    check("rdata_pass", 64'(blitr.rdata), 64'(data));
    check("rdvalid_pass", 64'(blitr.rdvalid), 64'd1);
    check("complete_pass", 64'(blitr.complete), 64'd1);
    @(negedge clock);
    sdram.rdvalid = 1'b0; sdram.complete = 1'b0;
    #1;
    check("rd_done_idle", 64'(dbg_state), 64'(ARB_IDLE));
  endtask

  task automatic serve(input int ack_dly, input int beat_dly, input logic [31:0] data);
    logic is_wr, ok;
    grant_and_ack(ack_dly, is_wr, ok);
    if (ok && !is_wr) read_finish(beat_dly, data);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 64'(dbg_state), 64'(ARB_IDLE));
    check({tag, "_streak"}, 64'(dbg_streak), 64'd0);
    check({tag, "_req"}, 64'(sdram.req), 64'd0);
    check({tag, "_write"}, 64'(sdram.write), 64'd0);
    check({tag, "_acks"}, 64'({blitw.ack, blitr.ack}), 64'd0);
    check({tag, "_busy"}, 64'(arb_busy), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic is_wr, ok;
    logic [31:0] d;
    sdram.ack = 1'b0; sdram.rdata = '0; sdram.rdvalid = 1'b0; sdram.complete = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 26'h100, 32'hDEADBEEF, 4'h3, 26'h0, 32'h0, 2, 0};
    vecs[1] = '{1'b0, 1'b1, 26'h0, 32'h0, 4'h0, 26'h200, 32'h12345678, 0, 2};
    vecs[2] = '{1'b1, 1'b1, 26'h300, 32'hA5A5_5A5A, 4'hC, 26'h400, 32'hCAFE_F00D, 1, 1};
    vecs[3] = '{1'b1, 1'b0, 26'($urandom), $urandom, 4'hF, 26'h0, 32'h0, 0, 0};
    vecs[4] = '{1'b0, 1'b1, 26'h0, 32'h0, 4'h0, 26'($urandom), $urandom, 1, 0};
    vecs[5] = '{1'b1, 1'b1, 26'($urandom), $urandom, 4'($urandom), 26'($urandom), $urandom, 0, 3};

    // Reset state; read passthrough follows its input even in reset.
    repeat (3) @(negedge clock);
    sdram.rdata = 32'h0000_0055; sdram.rdvalid = 1'b1;
    #1;
    check_reset_outputs("reset");
    check("reset_rdata_pass", 64'(blitr.rdata), 64'h55);
    check("reset_rdvalid_pass", 64'(blitr.rdvalid), 64'd1);
    sdram.rdvalid = 1'b0; sdram.rdata = '0;
    reset = 1'b0;
    @(negedge clock); #1;

    // Table-driven transactions; when both ports ask, the write goes first.
    foreach (vecs[i]) begin
      if (vecs[i].use_w) begin
        push_write(vecs[i].w_addr, vecs[i].w_data, vecs[i].w_be);
        exp_q.push_back({1'b1, vecs[i].w_addr, vecs[i].w_data, vecs[i].w_be});
      end
      if (vecs[i].use_r) begin
        push_read(vecs[i].r_addr);
        exp_q.push_back({1'b0, vecs[i].r_addr, 32'h0, 4'hF});
      end
      while (exp_q.size() > 0) begin
        serve(vecs[i].ack_dly, vecs[i].beat_dly, vecs[i].r_data);
      end
      @(negedge clock); #1;
      check("vec_idle", 64'(arb_busy), 64'd0);
    end

    // Both held continuously: MAX_WR_STREAK writes, one read, then writes resume.
    for (int i = 0; i < 11; i++) begin
      push_write(26'h1000 + 26'(i), 32'h7000_0000 + 32'(i), 4'hF);
    end
    push_read(26'h2000);
    for (int i = 0; i < 12; i++) begin
      if (i < MAX_WR_STREAK)       exp_q.push_back({1'b1, 26'h1000 + 26'(i), 32'h7000_0000 + 32'(i), 4'hF});
      else if (i == MAX_WR_STREAK) exp_q.push_back({1'b0, 26'h2000, 32'h0, 4'hF});
      else                         exp_q.push_back({1'b1, 26'h1000 + 26'(i-1), 32'h7000_0000 + 32'(i-1), 4'hF});
    end
    for (int i = 0; i < 12; i++) begin
      d = $urandom;
      serve($urandom_range(0, 2), $urandom_range(0, 2), d);
      if (i == MAX_WR_STREAK - 1) check("streak_at_limit", 64'(dbg_streak), 64'(MAX_WR_STREAK));
      if (i == MAX_WR_STREAK)     check("streak_clr_by_read", 64'(dbg_streak), 64'd0);
    end

    // Write arriving while a read is outstanding waits for complete.
    push_read(26'h3000);
    exp_q.push_back({1'b0, 26'h3000, 32'h0, 4'hF});
    grant_and_ack(1, is_wr, ok);
    push_write(26'h3100, 32'h1357_9BDF, 4'h5);
    exp_q.push_back({1'b1, 26'h3100, 32'h1357_9BDF, 4'h5});
    if (ok) read_finish(4, 32'h0BAD_F00D);
    serve(0, 0, 32'h0);

    // Streak counts while a read waits; reset mid-write clears it.
    push_write(26'h4000, 32'h1, 4'hF);
    push_write(26'h4001, 32'h2, 4'hF);
    push_write(26'h4002, 32'h3, 4'hF);
    push_read(26'h4100);
    exp_q.push_back({1'b1, 26'h4000, 32'h1, 4'hF});
    exp_q.push_back({1'b1, 26'h4001, 32'h2, 4'hF});
    serve(0, 0, 32'h0);
    serve(0, 0, 32'h0);
    check("streak_two", 64'(dbg_streak), 64'd2);
    @(negedge clock); #1;
    check("third_write_presented", 64'({sdram.req, sdram.write}), 64'd3);
    reset = 1'b1;
    w_pend_q.delete(); r_pend_q.delete(); exp_q.delete();
    @(negedge clock); #1;
    check_reset_outputs("rst_in_wr");
    reset = 1'b0;
    @(negedge clock); #1;

    // Reset during RD_WAIT, then stray read beats change nothing.
    push_read(26'h5000);
    exp_q.push_back({1'b0, 26'h5000, 32'h0, 4'hF});
    grant_and_ack(0, is_wr, ok);
    reset = 1'b1;
    @(negedge clock); #1;
    check_reset_outputs("rst_in_rdwait");
    reset = 1'b0;
    sdram.rdata = 32'h600D_BEEF; sdram.rdvalid = 1'b1; sdram.complete = 1'b1;
    #1;
    check("stray_rdata_pass", 64'(blitr.rdata), 64'h600D_BEEF);
    check("stray_complete_pass", 64'(blitr.complete), 64'd1);
    @(negedge clock);
    sdram.rdvalid = 1'b0; sdram.complete = 1'b0;
    #1;
    check("stray_state", 64'(dbg_state), 64'(ARB_IDLE));
    check("stray_busy", 64'(arb_busy), 64'd0);

    // Spurious downstream ack while idle.
    sdram.ack = 1'b1;
    #1;
    check("spurious_ack_up", 64'({blitw.ack, blitr.ack}), 64'd0);
    @(negedge clock);
    sdram.ack = 1'b0;
    #1;
    check("spurious_ack_state", 64'(dbg_state), 64'(ARB_IDLE));
    check("spurious_ack_req", 64'(sdram.req), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
